// File: rtl/led_pattern_ctrl_pkg.sv
// led_ctrl_pkg: mode encodings, initial LED patterns and SCAN turn points shared by the LED controller
package led_ctrl_pkg;
  typedef enum logic [1:0] {MODE_SCAN = 2'd0, MODE_FILL = 2'd1, MODE_BLINK = 2'd2} mode_e;
  localparam logic [7:0] INIT_SCAN = 8'h01;
  localparam logic [7:0] INIT_FILL = 8'h00;
  localparam logic [7:0] INIT_BLINK = 8'h55;
  localparam logic [7:0] SCAN_TURN_L = 8'h40;
  localparam logic [7:0] SCAN_TURN_R = 8'h02;
  function automatic logic [7:0] init_pat(mode_e m);
    return m == MODE_FILL ? INIT_FILL : m == MODE_BLINK ? INIT_BLINK : INIT_SCAN;
  endfunction
  function automatic mode_e next_mode(mode_e m);
    return m == MODE_BLINK ? MODE_SCAN : mode_e'(m + 2'd1);
  endfunction
endpackage

// File: rtl/led_pattern_ctrl_if.sv
// led_pattern_ctrl_if: button inputs and LED/status outputs of the LED controller
// Ports: master drives btn_mode/btn_speed/btn_pause, slave drives led/mode/speed/running/step
interface led_pattern_ctrl_if;
  logic btn_mode, btn_speed, btn_pause;
  logic [7:0] led;
  logic [1:0] mode, speed;
  logic running, step;
  modport master (output btn_mode, btn_speed, btn_pause, input led, mode, speed, running, step);
  modport slave (input btn_mode, btn_speed, btn_pause, output led, mode, speed, running, step);
endinterface

// File: rtl/led_pattern_ctrl_deb.sv
// btn_debounce: 2-flop synchroniser plus stability counter; one-cycle press on each accepted 0->1
// Ports: clk, rst (sync, active-high), raw in, level (accepted level) out, press (pulse) out
module btn_debounce #(
  parameter int DEB_CNT = 160000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int W = $clog2(DEB_CNT);
  logic [1:0] sync_q, sync_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, hit;
  always_ff @(posedge clk)
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  always_comb begin
    sync_d = {sync_q[0], raw};
    hit = sync_q[1] != level_q && cnt_q == W'(DEB_CNT - 1);
    cnt_d = (sync_q[1] == level_q || hit) ? '0 : cnt_q + W'(1);
    level_d = hit ? sync_q[1] : level_q;
    press_d = hit && sync_q[1];
    level = level_q;
    press = press_q;
  end
endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: 8-LED pattern sequencer (SCAN/FILL/BLINK) with step prescaler and debounced mode/speed/pause buttons
// Ports: clk, rst (sync, active-high); bus.slave: btn_mode/btn_speed/btn_pause in, led/mode/speed/running/step out
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 16000000,
  parameter int DEB_CNT = 160000
) (
  input logic clk,
  input logic rst,
  led_pattern_ctrl_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);
  logic [2:0] raw, press, unused_lvl;
  mode_e mode_q, mode_d;
  logic [1:0] speed_q, speed_d;
  logic [7:0] led_q, led_d, nxt_led;
  logic [CW-1:0] cnt_q, cnt_d, last;
  logic running_q, running_d, dir_q, dir_d, step_q, step_d, tc, reload;
  assign raw = {bus.btn_pause, bus.btn_speed, bus.btn_mode};
  for (genvar i = 0; i < 3; i++) begin : g_deb
    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
      .clk(clk), .rst(rst), .raw(raw[i]), .level(unused_lvl[i]), .press(press[i])
    );
  end
  always_ff @(posedge clk)
    if (rst) begin
      mode_q <= MODE_SCAN;
      speed_q <= '0;
      led_q <= INIT_SCAN;
      cnt_q <= '0;
      running_q <= 1'b1;
      dir_q <= 1'b1;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      speed_q <= speed_d;
      led_q <= led_d;
      cnt_q <= cnt_d;
      running_q <= running_d;
      dir_q <= dir_d;
      step_q <= step_d;
    end
  // A mode or speed press restarts the period, swallowing a coincident terminal count.
  always_comb begin
    last = CW'((TICK_DIV >> speed_q) - 1);
    tc = running_q && cnt_q == last;
    reload = press[0] || press[1];
    step_d = tc && !reload;
    cnt_d = (reload || tc) ? '0 : cnt_q + CW'(running_q);
    mode_d = press[0] ? next_mode(mode_q) : mode_q;
    speed_d = speed_q + {1'b0, press[1]};
    running_d = running_q ^ press[2];
    nxt_led = mode_q == MODE_SCAN ? (dir_q ? {led_q[6:0], led_q[7]} : {led_q[0], led_q[7:1]})
            : mode_q == MODE_FILL ? (led_q == 8'hFF ? 8'h00 : {led_q[6:0], 1'b1})
            : ~led_q;
    led_d = press[0] ? init_pat(mode_d) : step_d ? nxt_led : led_q;
    // Turn one step before the end so each end LED stays lit for exactly one step.
    dir_d = press[0] ? 1'b1
          : step_d && mode_q == MODE_SCAN ? (dir_q ? led_q != SCAN_TURN_L : led_q == SCAN_TURN_R)
          : dir_q;
  end
  always_comb begin
    bus.led = led_q;
    bus.mode = mode_q;
    bus.speed = speed_q;
    bus.running = running_q;
    bus.step = step_q;
  end
endmodule
